// File: rtl/pwm_config_controller.sv
// PWM generator with a programmable tick divider and a double-buffered
// configuration. Changes offered while the generator runs are parked in
// shadow registers and applied only at a PWM period boundary, so a tick
// or period is never cut short by a reconfiguration.
module pwm_config_controller #(
  parameter int          DIV_W   = 16,
  parameter int          DUTY_W  = 8,
  parameter int unsigned RST_DIV = 4999
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DUTY_W-1:0] cfg_duty,
  output logic              tick,
  output logic              period_start,
  output logic              pwm_out,
  output logic              cfg_pending
);

  localparam logic [DIV_W-1:0] RST_DIV_V = DIV_W'(RST_DIV);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [DUTY_W-1:0]   duty_cnt_q, duty_cnt_d;
  logic [DIV_W-1:0]    act_div_q, act_div_d;
  logic [DUTY_W-1:0]   act_duty_q, act_duty_d;
  logic [DIV_W-1:0]    sh_div_q, sh_div_d;
  logic [DUTY_W-1:0]   sh_duty_q, sh_duty_d;
  logic                pwm_q, pwm_d;

  logic running;
  logic div_wrap;
  logic tick_c;
  logic period_start_c;
  logic ready_c;
  logic xfer;

  // Status decode shared by the outputs and the next-state logic.
  always_comb begin
    running        = (state_q != S_IDLE);
    div_wrap       = (div_cnt_q == act_div_q);
    tick_c         = running && div_wrap;
    period_start_c = tick_c && (duty_cnt_q == {DUTY_W{1'b1}});
    ready_c        = (state_q != S_PEND);
    xfer           = cfg_valid && ready_c;
  end

  assign tick         = tick_c;
  assign period_start = period_start_c;
  assign cfg_ready    = ready_c;
  assign cfg_pending  = (state_q == S_PEND);
  assign pwm_out      = pwm_q;

  // Next-state, counter and configuration-register logic.
  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    duty_cnt_d = duty_cnt_q;
    act_div_d  = act_div_q;
    act_duty_d = act_duty_q;
    sh_div_d   = sh_div_q;
    sh_duty_d  = sh_duty_q;
    pwm_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Counters are held at zero so a later start begins a fresh period.
        div_cnt_d  = '0;
        duty_cnt_d = '0;
        if (xfer) begin
          act_div_d  = cfg_div;
          act_duty_d = cfg_duty;
        end
        if (enable) begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (!enable) begin
          // Stopping: an offer accepted on the same edge goes straight to
          // the active registers since no period is in progress afterwards.
          state_d    = S_IDLE;
          div_cnt_d  = '0;
          duty_cnt_d = '0;
          if (xfer) begin
            act_div_d  = cfg_div;
            act_duty_d = cfg_duty;
          end
        end else begin
          if (div_wrap) begin
            div_cnt_d  = '0;
            duty_cnt_d = duty_cnt_q + DUTY_W'(1);
          end else begin
            div_cnt_d  = div_cnt_q + DIV_W'(1);
          end
          pwm_d = (duty_cnt_q < act_duty_q);
          // A transfer on a boundary cycle still lets the current boundary
          // pass with the old settings; the new ones wait a full period.
          if (xfer) begin
            sh_div_d  = cfg_div;
            sh_duty_d = cfg_duty;
            state_d   = S_PEND;
          end
        end
      end

      S_PEND: begin
        if (!enable) begin
          state_d    = S_IDLE;
          div_cnt_d  = '0;
          duty_cnt_d = '0;
          act_div_d  = sh_div_q;
          act_duty_d = sh_duty_q;
        end else begin
          if (div_wrap) begin
            div_cnt_d  = '0;
            duty_cnt_d = duty_cnt_q + DUTY_W'(1);
          end else begin
            div_cnt_d  = div_cnt_q + DIV_W'(1);
          end
          pwm_d = (duty_cnt_q < act_duty_q);
          if (period_start_c) begin
            // Period boundary: swap in the shadow set and restart counting.
            act_div_d  = sh_div_q;
            act_duty_d = sh_duty_q;
            div_cnt_d  = '0;
            duty_cnt_d = '0;
            state_d    = S_RUN;
          end
        end
      end

      default: begin
        state_d    = S_IDLE;
        div_cnt_d  = '0;
        duty_cnt_d = '0;
      end
    endcase
  end

  // State, counters, configuration and PWM output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      div_cnt_q  <= '0;
      duty_cnt_q <= '0;
      act_div_q  <= RST_DIV_V;
      act_duty_q <= '0;
      sh_div_q   <= '0;
      sh_duty_q  <= '0;
      pwm_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      duty_cnt_q <= duty_cnt_d;
      act_div_q  <= act_div_d;
      act_duty_q <= act_duty_d;
      sh_div_q   <= sh_div_d;
      sh_duty_q  <= sh_duty_d;
      pwm_q      <= pwm_d;
    end
  end

endmodule

// File: tb/tb_pwm_config_controller.sv
// Bench for pwm_config_controller: directed scenarios plus a randomized
// phase, every cycle compared against a timing-based reference model.
module tb_pwm_config_controller;

  localparam int DIV_W   = 16;
  localparam int DUTY_W  = 8;
  localparam int RST_DIV = 4999;
  localparam int PER     = 1 << DUTY_W;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              enable;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [DIV_W-1:0]  cfg_div;
  logic [DUTY_W-1:0] cfg_duty;
  logic              tick;
  logic              period_start;
  logic              pwm_out;
  logic              cfg_pending;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: clocks elapsed since the current period began.
  bit     m_run, m_pend, m_pwm;
  longint m_div, m_duty, m_sdiv, m_sduty, m_t;

  pwm_config_controller #(
    .DIV_W  (DIV_W),
    .DUTY_W (DUTY_W),
    .RST_DIV(RST_DIV)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_div     (cfg_div),
    .cfg_duty    (cfg_duty),
    .tick        (tick),
    .period_start(period_start),
    .pwm_out     (pwm_out),
    .cfg_pending (cfg_pending)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pend = 0; m_pwm = 0;
    m_div = RST_DIV; m_duty = 0; m_sdiv = 0; m_sduty = 0; m_t = 0;
  endtask

  function automatic longint period_len();
    return (m_div + 1) * PER;
  endfunction

  function automatic bit at_boundary();
    return m_run && (m_t == period_len() - 1);
  endfunction

  task automatic check_outputs();
    bit e_tick;
    e_tick = m_run && (((m_t + 1) % (m_div + 1)) == 0);
    chk("tick", tick, e_tick);
    chk("period_start", period_start, at_boundary());
    chk("pwm_out", pwm_out, m_pwm);
    chk("cfg_ready", cfg_ready, !m_pend);
    chk("cfg_pending", cfg_pending, m_pend);
  endtask

  // Advance the model across one rising edge with the given inputs.
  task automatic model_edge(input bit en, input bit v, input longint d, input longint u);
    bit xfer, npwm, bnd;
    xfer = v && !m_pend;
    npwm = m_run && en && ((m_t / (m_div + 1)) < m_duty);
    bnd  = at_boundary();
    if (!m_run) begin
      if (xfer) begin m_div = d; m_duty = u; end
      if (en) begin m_run = 1; m_t = 0; end
    end else if (!en) begin
      if (m_pend) begin m_div = m_sdiv; m_duty = m_sduty; end
      else if (xfer) begin m_div = d; m_duty = u; end
      m_run = 0; m_pend = 0; m_t = 0;
    end else begin
      m_t = bnd ? 0 : m_t + 1;
      if (m_pend && bnd) begin
        m_div = m_sdiv; m_duty = m_sduty; m_pend = 0;
      end else if (xfer) begin
        m_sdiv = d; m_sduty = u; m_pend = 1;
      end
    end
    m_pwm = npwm;
  endtask

  task automatic step(input bit en, input bit v, input int d, input int u);
    enable    = en;
    cfg_valid = v;
    cfg_div   = DIV_W'(d);
    cfg_duty  = DUTY_W'(u);
    @(posedge clock);
    model_edge(en, v, d, u);
    @(negedge clock);
    check_outputs();
  endtask

  task automatic run_first_tick(input string tag);
    int first;
    first = -1;
    for (int k = 1; k <= RST_DIV + 2; k++) begin
      step(1, 0, 0, 0);
      if (tick && first < 0) first = k;
    end
    chk_int(tag, first, RST_DIV + 1);
  endtask

  initial begin
    int hi_cnt, tk_cnt, guard;
    reset_n = 1'b0; enable = 1'b0; cfg_valid = 1'b0; cfg_div = '0; cfg_duty = '0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clock);
    @(negedge clock);
    check_outputs();
    reset_n = 1'b1;

    // Defaults: first tick 5000 clocks after the enable edge, pwm stays low.
    run_first_tick("first_tick_default");

    // Stop, configure in IDLE, restart: 1/4 duty over a 1024-clock period.
    step(0, 0, 0, 0);
    step(0, 1, 3, 64);
    hi_cnt = 0; tk_cnt = 0;
    for (int k = 1; k <= 1100; k++) begin
      step(1, 0, 0, 0);
      if (k >= 2 && k <= 1025 && pwm_out) hi_cnt++;
      if (k <= 1024 && tick) tk_cnt++;
    end
    chk_int("pwm_high_per_period", hi_cnt, 256);
    chk_int("ticks_per_period", tk_cnt, 256);

    // Mid-period reconfiguration held until the boundary.
    step(1, 1, 1, 128);
    chk("ready_low_in_pend", cfg_ready, 1'b0);
    guard = 0;
    while (m_pend && guard < 2000) begin step(1, 0, 0, 0); guard++; end
    chk("pend_resolved", m_pend, 1'b0);
    for (int k = 0; k < 600; k++) step(1, 0, 0, 0);

    // Transfer on the very cycle of period_start.
    guard = 0;
    while (!at_boundary() && guard < 3000) begin step(1, 0, 0, 0); guard++; end
    chk("reached_boundary", period_start, 1'b1);
    step(1, 1, 2, 200);
    chk("pend_after_coincident", cfg_pending, 1'b1);
    for (int k = 0; k < 1400; k++) step(1, 0, 0, 0);

    // Randomized traffic, including duty extremes and enable drops.
    for (int k = 0; k < 6000; k++) begin
      int u, sel;
      sel = $urandom_range(0, 3);
      u = (sel == 0) ? 0 : (sel == 1) ? PER - 1 : $urandom_range(0, PER - 1);
      step($urandom_range(0, 99) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3), u);
    end

    // Enable dropped while a shadow configuration is pending.
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 2, 30);
    for (int k = 0; k < 10; k++) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("ready_after_pend_drop", cfg_ready, 1'b1);
    chk("pwm_after_pend_drop", pwm_out, 1'b0);
    for (int k = 0; k < 800; k++) step(1, 0, 0, 0);

    // Reset pulsed mid-PEND: outputs clear at once, shadow discarded.
    step(1, 1, 1, 50);
    for (int k = 0; k < 5; k++) step(1, 0, 0, 0);
    chk("in_pend_before_reset", cfg_pending, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clock);
    reset_n = 1'b1;
    run_first_tick("first_tick_after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
